// File: rtl/bpi_cmd_fifo_arbiter.sv
// Two-source arbiter for the BPI command FIFO write port; keeps each command atomic and aborts abandoned or stalled ones.
// Define BPI_ARB_TIMEOUT_EN to build in the stall counter and timeout abort.
module bpi_cmd_fifo_arbiter #(
  parameter int DW      = 16,
  parameter int TMO_CYC = 1023
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    REQ,
  input  logic [1:0]    WR,
  input  logic [1:0]    LAST,
  input  logic [DW-1:0] DIN0,
  input  logic [DW-1:0] DIN1,
  input  logic          FF_FULL,
  output logic [1:0]    GNT,
  output logic [1:0]    ACC,
  output logic          FF_WE,
  output logic [DW-1:0] FF_DIN,
  output logic          BUSY,
  output logic          ABORT,
  output logic          ABORT_SRC,
  output logic [7:0]    WORD_CNT,
  output logic [1:0]    OUT_STATE
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_OWNED = 2'b01;
  localparam logic [1:0] S_ABORT = 2'b10;

  logic [1:0] r_state, w_next;
  logic [1:0] r_gnt;
  logic       r_pri;
  logic       r_abort_src;
  logic [7:0] r_word_cnt;
  logic [1:0] w_win, w_acc;
  logic       w_g, w_acc_any, w_last_acc, w_tmo;

  always_comb begin
    w_win = 2'b00;
    case (REQ)
      2'b01:   w_win = 2'b01;
      2'b10:   w_win = 2'b10;
      2'b11:   w_win = r_pri ? 2'b10 : 2'b01;
      default: w_win = 2'b00;
    endcase
  end

  // r_gnt is one-hot, so bit 1 doubles as the owner index
  assign w_g        = r_gnt[1];
  assign w_acc      = (r_state == S_OWNED) ? (r_gnt & WR & {2{~FF_FULL}}) : 2'b00;
  assign w_acc_any  = |w_acc;
  assign w_last_acc = w_acc_any & LAST[w_g];

`ifdef BPI_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LIM = 10'(TMO_CYC - 1);
  logic [9:0] r_stall;

  // Holds while the FIFO is full so backpressure alone never aborts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      r_stall <= '0;
    else if (r_state != S_OWNED)  r_stall <= '0;
    else if (w_acc_any)           r_stall <= '0;
    else if (!FF_FULL)            r_stall <= r_stall + 10'd1;
  end

  assign w_tmo = (r_state == S_OWNED) & ~w_acc_any & ~FF_FULL & (r_stall == TMO_LIM);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^10'(TMO_CYC);
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Accepted LAST outranks both REQ drop and timeout.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = (|REQ) ? S_OWNED : S_IDLE;
      S_OWNED: begin
        if (w_last_acc)              w_next = S_IDLE;
        else if (!REQ[w_g] || w_tmo) w_next = S_ABORT;
        else                         w_next = S_OWNED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gnt       <= 2'b00;
      r_pri       <= 1'b0;
      r_abort_src <= 1'b0;
      r_word_cnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (|REQ) begin
          r_gnt      <= w_win;
          r_word_cnt <= 8'd0;
        end
        S_OWNED: begin
          if (w_acc_any && r_word_cnt != 8'hFF) r_word_cnt <= r_word_cnt + 8'd1;
          if (w_next != S_OWNED) begin
            r_gnt <= 2'b00;
            r_pri <= ~w_g;
          end
          if (w_next == S_ABORT) r_abort_src <= w_g;
        end
        default: r_gnt <= 2'b00;
      endcase
    end
  end

  always_comb begin
    GNT       = r_gnt;
    ACC       = w_acc;
    FF_WE     = w_acc_any;
    FF_DIN    = w_g ? DIN1 : DIN0;
    BUSY      = (r_state != S_IDLE);
    ABORT     = (r_state == S_ABORT);
    ABORT_SRC = r_abort_src;
    WORD_CNT  = r_word_cnt;
    OUT_STATE = r_state;
  end
endmodule

// File: tb/tb_bpi_cmd_fifo_arbiter.sv
// Directed bench for bpi_cmd_fifo_arbiter; timeout steps follow BPI_ARB_TIMEOUT_EN.
module tb_bpi_cmd_fifo_arbiter;
  logic        CLK, RST;
  logic [1:0]  REQ, WR, LAST;
  logic [15:0] DIN0, DIN1;
  logic        FF_FULL;
  logic [1:0]  GNT, ACC, OUT_STATE;
  logic        FF_WE, BUSY, ABORT, ABORT_SRC;
  logic [15:0] FF_DIN;
  logic [7:0]  WORD_CNT;

  int errors = 0;
  int checks = 0;
  int seen;
  int j;

  bpi_cmd_fifo_arbiter #(.DW(16), .TMO_CYC(1023)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WR(WR), .LAST(LAST), .DIN0(DIN0), .DIN1(DIN1),
    .FF_FULL(FF_FULL), .GNT(GNT), .ACC(ACC), .FF_WE(FF_WE), .FF_DIN(FF_DIN), .BUSY(BUSY),
    .ABORT(ABORT), .ABORT_SRC(ABORT_SRC), .WORD_CNT(WORD_CNT), .OUT_STATE(OUT_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checking.
  task automatic drv(input logic [1:0] req, input logic [1:0] wr, input logic [1:0] last,
                     input logic [15:0] d0, input logic [15:0] d1, input logic full);
    @(negedge CLK);
    REQ = req; WR = wr; LAST = last; DIN0 = d0; DIN1 = d1; FF_FULL = full;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = 2'b00; WR = 2'b00; LAST = 2'b00; FF_FULL = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; REQ = 2'b00; WR = 2'b00; LAST = 2'b00; DIN0 = '0; DIN1 = '0; FF_FULL = 1'b0;
    #3;
    chk("rst_gnt", GNT, 0);      chk("rst_acc", ACC, 0);   chk("rst_we", FF_WE, 0);
    chk("rst_busy", BUSY, 0);    chk("rst_abort", ABORT, 0);
    chk("rst_src", ABORT_SRC, 0); chk("rst_wcnt", WORD_CNT, 0); chk("rst_state", OUT_STATE, 0);
    @(negedge CLK); RST = 1'b0;

    // single 3-word command from requester 0
    drv(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t1_idle_gnt", GNT, 0);
    drv(2'b01, 2'b01, 2'b00, 16'hA001, 16'h0000, 1'b0);
    chk("t1_gnt", GNT, 2'b01); chk("t1_acc1", ACC, 2'b01); chk("t1_we1", FF_WE, 1);
    chk("t1_din1", FF_DIN, 16'hA001); chk("t1_state", OUT_STATE, 1); chk("t1_busy", BUSY, 1);
    drv(2'b01, 2'b01, 2'b00, 16'hA002, 16'h0000, 1'b0);
    chk("t1_din2", FF_DIN, 16'hA002); chk("t1_wcnt1", WORD_CNT, 1);
    drv(2'b01, 2'b01, 2'b01, 16'hA003, 16'h0000, 1'b0);
    chk("t1_din3", FF_DIN, 16'hA003); chk("t1_wcnt2", WORD_CNT, 2); chk("t1_acc3", ACC, 2'b01);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t1_gnt_off", GNT, 0); chk("t1_wcnt3", WORD_CNT, 3); chk("t1_acc_off", ACC, 0);
    chk("t1_idle", BUSY, 0);

    // both request from reset: 0 first, one idle cycle, then 1
    do_reset();
    drv(2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b11, 2'b11, 2'b00, 16'hB001, 16'hC001, 1'b0);
    chk("t2_gnt0", GNT, 2'b01); chk("t2_acc0", ACC, 2'b01); chk("t2_din_b1", FF_DIN, 16'hB001);
    drv(2'b11, 2'b11, 2'b01, 16'hB002, 16'hC001, 1'b0);
    chk("t2_acc0b", ACC, 2'b01); chk("t2_din_b2", FF_DIN, 16'hB002);
    drv(2'b10, 2'b10, 2'b10, 16'h0000, 16'hC001, 1'b0);
    chk("t2_gap_gnt", GNT, 0); chk("t2_gap_we", FF_WE, 0);
    drv(2'b10, 2'b10, 2'b10, 16'h0000, 16'hC001, 1'b0);
    chk("t2_gnt1", GNT, 2'b10); chk("t2_acc1", ACC, 2'b10); chk("t2_din_c1", FF_DIN, 16'hC001);
    chk("t2_wcnt0", WORD_CNT, 0);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t2_done", GNT, 0); chk("t2_wcnt1", WORD_CNT, 1);

    // long FIFO backpressure mid-command never aborts
    drv(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b01, 2'b01, 2'b00, 16'hD001, 16'h0000, 1'b0);
    chk("t3_acc1", ACC, 2'b01);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      drv(2'b01, 2'b01, 2'b00, 16'hD002, 16'h0000, 1'b1);
      if (ABORT || FF_WE) seen++;
    end
    chk("t3_no_abort", seen, 0); chk("t3_gnt_hold", GNT, 2'b01);
    drv(2'b01, 2'b01, 2'b00, 16'hD002, 16'h0000, 1'b0);
    chk("t3_acc2", ACC, 2'b01); chk("t3_din2", FF_DIN, 16'hD002);
    drv(2'b01, 2'b01, 2'b01, 16'hD003, 16'h0000, 1'b0);
    chk("t3_din3", FF_DIN, 16'hD003);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t3_wcnt", WORD_CNT, 3); chk("t3_gnt_off", GNT, 0); chk("t3_abort", ABORT, 0);

    // requester 1 stalls after 2 words
    drv(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b10, 2'b10, 2'b00, 16'h0000, 16'hE001, 1'b0);
    chk("t4_acc1", ACC, 2'b10);
    drv(2'b10, 2'b10, 2'b00, 16'h0000, 16'hE002, 1'b0);
    chk("t4_din2", FF_DIN, 16'hE002);
`ifdef BPI_ARB_TIMEOUT_EN
    j = 1101;
    for (int k = 1; k <= 1100; k++) begin
      drv(2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
      if (ABORT) begin j = k; break; end
    end
    chk("t4_tmo_cycle", j, 1024); chk("t4_src", ABORT_SRC, 1); chk("t4_gnt", GNT, 0);
    chk("t4_state", OUT_STATE, 2);
    drv(2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t4_pulse", ABORT, 0); chk("t4_idle_gnt", GNT, 0);
    drv(2'b11, 2'b01, 2'b01, 16'hE100, 16'h0000, 1'b0);
    chk("t4_next_gnt", GNT, 2'b01); chk("t4_next_acc", ACC, 2'b01);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t4_done", GNT, 0);
`else
    seen = 0;
    for (int k = 0; k < 1100; k++) begin
      drv(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
      if (ABORT || GNT != 2'b10) seen++;
    end
    chk("t4_no_tmo", seen, 0);
    drv(2'b10, 2'b10, 2'b10, 16'h0000, 16'hE003, 1'b0);
    chk("t4_acc3", ACC, 2'b10);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t4_wcnt", WORD_CNT, 3); chk("t4_done", GNT, 0);
`endif

    // REQ[0] drops after one word
    drv(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b01, 2'b01, 2'b00, 16'hF001, 16'h0000, 1'b0);
    chk("t5_acc", ACC, 2'b01);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t5_pre_abort", ABORT, 0); chk("t5_pre_gnt", GNT, 2'b01);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t5_abort", ABORT, 1); chk("t5_src", ABORT_SRC, 0); chk("t5_gnt", GNT, 0);
    chk("t5_busy", BUSY, 1);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t5_pulse_end", ABORT, 0); chk("t5_idle", OUT_STATE, 0);

    // LAST accepted in the same cycle REQ drops completes normally
    drv(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b00, 2'b10, 2'b10, 16'h0000, 16'h1234, 1'b0);
    chk("t6_acc", ACC, 2'b10); chk("t6_din", FF_DIN, 16'h1234);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t6_no_abort", ABORT, 0); chk("t6_state", OUT_STATE, 0);

    // reset mid-command drops everything immediately
    drv(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    drv(2'b10, 2'b10, 2'b00, 16'h0000, 16'h5555, 1'b0);
    chk("t7_acc", ACC, 2'b10);
    RST = 1'b1;
    #1;
    chk("t7_gnt", GNT, 0); chk("t7_acc_rst", ACC, 0); chk("t7_we", FF_WE, 0);
    chk("t7_busy", BUSY, 0); chk("t7_abort", ABORT, 0); chk("t7_wcnt", WORD_CNT, 0);
    chk("t7_state", OUT_STATE, 0);
    @(negedge CLK);
    REQ = 2'b00; WR = 2'b00;
    @(negedge CLK);
    RST = 1'b0;

    // WORD_CNT saturates at 255
    drv(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 299; i++) drv(2'b01, 2'b01, 2'b00, 16'(i), 16'h0000, 1'b0);
    drv(2'b01, 2'b01, 2'b01, 16'h0FFF, 16'h0000, 1'b0);
    chk("t8_sat", WORD_CNT, 255);
    drv(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0);
    chk("t8_sat_end", WORD_CNT, 255); chk("t8_gnt", GNT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bpi_cmd_fifo_arbiter.md
# bpi_cmd_fifo_arbiter

Shares the BPI command FIFO write port between two command sources. Requester 0 is the VME register interface; requester 1 is the internal PROM loader. Each source writes multi-word commands. The arbiter grants one requester at a time and keeps every command atomic: a grant is held until that requester's last word, so words from the two sources never interleave. It also aborts stalled or abandoned commands so the downstream command parser never waits indefinitely on a half-written command.

## Interface
Parameters:
- DW, 16, command word width.
- TMO_CYC, 1023, stall cycles before abort (10-bit counter; legal range 1..1023).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- REQ  in  2  per-requester request; held high for the whole command.
- WR  in  2  per-requester word-valid; DIN stable while high.
- LAST  in  2  marks the current word as the final word of the command.
- DIN0  in  DW  requester 0 data.
- DIN1  in  DW  requester 1 data.
- FF_FULL  in  1  command FIFO full.
- GNT  out  2  one-hot grant, registered.
- ACC  out  2  word accepted this cycle, combinational.
- FF_WE  out  1  FIFO write enable, combinational.
- FF_DIN  out  DW  FIFO write data, combinational mux of the granted DIN.
- BUSY  out  1  state is not IDLE.
- ABORT  out  1  one-cycle pulse; downstream uses it to flush the FIFO and reset the parser.
- ABORT_SRC  out  1  index of the requester whose command was last aborted.
- WORD_CNT  out  8  words accepted in the current command.
- OUT_STATE  out  2  state encoding for debug.

## Operation
States: IDLE=2'b00, OWNED=2'b01, ABORT=2'b10.

IDLE:
- GNT=0.
- If any REQ is high, the winner is set in GNT and the state moves to OWNED on the next edge.
- Winner: a sole requester wins outright. If both request, the round-robin pointer PRI picks.
- On entry to OWNED, WORD_CNT clears and the stall counter clears.

OWNED (requester g):
- ACC[g] = WR[g] & !FF_FULL. FF_WE = ACC[g]. FF_DIN = DIN of g.
- WR on a non-granted requester is ignored; its ACC stays 0.
- Each accepted word increments WORD_CNT, saturating at 255, and clears the stall counter.
- Accepted word with LAST[g]=1: next state IDLE, GNT clears, PRI becomes the other requester.
- REQ[g] low with no accepted LAST: next state ABORT.
- The stall counter increments in cycles with no acceptance and FF_FULL=0. It holds while FF_FULL=1, so FIFO backpressure never causes an abort.
- Stall counter reaching TMO_CYC: next state ABORT.

ABORT:
- Lasts one cycle. ABORT=1, GNT=0, ABORT_SRC<=g.
- PRI becomes the other requester.
- Next state IDLE.

Any unused state encoding goes to IDLE.

Simultaneous events:
- Acceptance of LAST beats both REQ drop and timeout in the same cycle; the command completes normally.
- A word accepted in the same cycle the counter would reach TMO_CYC resets the counter; no abort.

Reset values:
- State IDLE.
- GNT=0, ACC=0, FF_WE=0, BUSY=0, ABORT=0, ABORT_SRC=0, WORD_CNT=0, PRI=0, stall counter=0.
- RST asserted mid-command drops the grant immediately, with no ABORT pulse. Flushing the FIFO on RST is the system's job.

## Timing
- REQ high in IDLE at edge n gives GNT at n+1. The first word can be accepted in cycle n+1.
- Write path has zero latency: the word is written into the FIFO in the same cycle ACC is high.
- LAST accepted at edge m: GNT low at m+1. The earliest next grant is m+2, so there is exactly one IDLE cycle between commands.
- Timeout fires on exactly the TMO_CYC-th consecutive non-full, non-accepting cycle. ABORT pulses on the following cycle.

## Configuration
- BPI_ARB_TIMEOUT_EN defined: stall counter and timeout abort are present as described above.
- Not defined:
  - The stall counter is removed and abort happens only on REQ drop.
  - TMO_CYC is unused.
  - All other behaviour is unchanged.

## Test plan
- Single 3-word command from requester 0, FF_FULL=0: GNT=2'b01 one cycle after REQ; ACC/FF_WE high for 3 cycles with FF_DIN=DIN0 values; WORD_CNT=3; GNT=0 the cycle after LAST.
- Both REQ high from reset: requester 0 is served first (PRI=0), then requester 1 after one IDLE cycle; no interleaved FIFO words.
- FF_FULL held high for 2000 cycles mid-command, with TMO_CYC=1023 and the macro defined: no ABORT; after FF_FULL drops, the remaining words are written.
- Requester 1 stalls with WR=0 after 2 words, macro defined: ABORT pulses on cycle 1024 after the last acceptance; ABORT_SRC=1; GNT=0; requester 0 is granted next.
- REQ[0] drops after 1 word: ABORT the next cycle, ABORT_SRC=0. Rerun without BPI_ARB_TIMEOUT_EN and a stalled requester: no ABORT ever.
- RST asserted in OWNED: all outputs return to reset values immediately; ABORT stays 0.
